// File: rtl/calc_pkg.sv
// Shared constants, FSM state type and digit helper for the calculator display path.
package calc_pkg;

  localparam int BIN_W          = 32;
  localparam int DIGITS         = 6;
  localparam int SCRATCH_DIGITS = 10;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Double-dabble correction: a digit of 5 or more would overflow past 9 on the next doubling.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bin_to_bcd_if.sv
// Request/result bundle between the arithmetic unit and the binary-to-BCD decoder.
interface bin_to_bcd_if
  import calc_pkg::*;
();

  logic                start;
  logic [BIN_W-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                neg;
  logic                ovf;
  logic [DIGITS-1:0]   blank;

  modport master (
    output start, bin,
    input  busy, done, bcd, neg, ovf, blank
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, neg, ovf, blank
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// One scratch digit of the shift-and-add-3 converter: adds 3 when the digit is 5 or more.
module bcd_digit_adjust
  import calc_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = add3_if_ge5(din);

endmodule

// File: rtl/bin_to_bcd.sv
// Iterative 32-bit two's-complement to sign + six BCD digits converter, one bit per clock.
module bin_to_bcd
  import calc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  bin_to_bcd_if.slave  bus
);

  localparam int CNT_W = $clog2(BIN_W);
  localparam int SW    = 4 * SCRATCH_DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  state_t              state, state_nxt;
  logic [BIN_W-1:0]    mag;
  logic [SW-1:0]       scratch, adj, scratch_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                sign;
  logic                last;
  logic                ovf_nxt;
  logic                hz;
  logic [DIGITS-1:0]   blank_nxt;

  logic [4*DIGITS-1:0] bcd_q;
  logic                neg_q, ovf_q, done_q;
  logic [DIGITS-1:0]   blank_q;

  for (genvar i = 0; i < SCRATCH_DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (scratch[4*i +: 4]),
      .dout (adj[4*i +: 4])
    );
  end

  // The magnitude MSB shifts into the scratch LSB; a carry out of the top digit can only mean overflow.
  assign scratch_nxt = {adj[SW-2:0], mag[BIN_W-1]};
  assign last        = (cnt == CNT_W'(BIN_W - 1));
  assign ovf_nxt     = adj[SW-1] | (scratch_nxt[SW-1:4*DIGITS] != '0);

  // Digit i is a leading zero only if it and every more significant digit are zero.
  always_comb begin
    blank_nxt = '0;
    hz        = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hz           = hz & (scratch_nxt[4*i +: 4] == 4'd0);
      blank_nxt[i] = hz & ~ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag     <= '0;
      scratch <= '0;
      cnt     <= '0;
      sign    <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      blank_q <= BLANK_RST;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign    <= bus.bin[BIN_W-1];
            mag     <= bus.bin[BIN_W-1] ? (~bus.bin + BIN_W'(1)) : bus.bin;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          mag     <= {mag[BIN_W-2:0], 1'b0};
          cnt     <= cnt + CNT_W'(1);
          // Results are committed together from this cycle's shift so they never update piecemeal.
          if (last) begin
            bcd_q   <= scratch_nxt[4*DIGITS-1:0];
            ovf_q   <= ovf_nxt;
            neg_q   <= sign;
            blank_q <= blank_nxt;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state == SHIFT);
  assign bus.done  = done_q;
  assign bus.bcd   = bcd_q;
  assign bus.neg   = neg_q;
  assign bus.ovf   = ovf_q;
  assign bus.blank = blank_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Randomised self-checking bench for bin_to_bcd against an arithmetic decimal reference model.
module tb_bin_to_bcd;
  import calc_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bin_to_bcd_if bus ();

  bin_to_bcd dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference: plain decimal arithmetic on the signed value.
  task automatic model(input logic [31:0] v, output logic [23:0] bcd, output logic neg,
                       output logic ovf, output logic [5:0] blank);
    longint sv, m, low;
    logic   hz;
    sv    = longint'($signed(v));
    neg   = (sv < 0);
    m     = neg ? -sv : sv;
    ovf   = (m > 999999);
    low   = m % 1000000;
    bcd   = '0;
    for (int i = 0; i < 6; i++) begin
      bcd[4*i +: 4] = 4'(low % 10);
      low = low / 10;
    end
    blank = '0;
    hz    = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      hz       = hz & (bcd[4*i +: 4] == 4'd0);
      blank[i] = hz & ~ovf;
    end
  endtask

  task automatic checkResult(input logic [31:0] v);
    logic [23:0] e_bcd;
    logic        e_neg, e_ovf;
    logic [5:0]  e_blank;
    model(v, e_bcd, e_neg, e_ovf, e_blank);
    checkOutput("bcd",   64'(bus.bcd),   64'(e_bcd));
    checkOutput("neg",   64'(bus.neg),   64'(e_neg));
    checkOutput("ovf",   64'(bus.ovf),   64'(e_ovf));
    checkOutput("blank", 64'(bus.blank), 64'(e_blank));
  endtask

  // Waits for done (sampled 1 after each rising edge) and returns cycles elapsed.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.done === 1'b1) checkOutput("busy_with_done", 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] v);
    int cycles;
    @(negedge clk);
    bus.bin   = v;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bin   = $urandom;
    checkOutput("busy_after_start", 64'(bus.busy), 64'd1);
    waitDone(cycles);
    checkOutput("latency", 64'(cycles), 64'd32);
    checkResult(v);
    @(posedge clk); #1;
    checkOutput("done_one_cycle", 64'(bus.done), 64'd0);
    checkResult(v);
  endtask

  initial begin
    int          cycles, pulses;
    logic [31:0] v;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    checkOutput("rst_bcd",   64'(bus.bcd),   64'd0);
    checkOutput("rst_neg",   64'(bus.neg),   64'd0);
    checkOutput("rst_ovf",   64'(bus.ovf),   64'd0);
    checkOutput("rst_blank", 64'(bus.blank), 64'b111110);
    checkOutput("rst_busy",  64'(bus.busy),  64'd0);
    checkOutput("rst_done",  64'(bus.done),  64'd0);

    applyStimulus(32'd123);
    checkOutput("dir_123", 64'(bus.bcd), 64'h000123);
    applyStimulus(-32'sd45);
    checkOutput("dir_m45_blank", 64'(bus.blank), 64'b111100);
    applyStimulus(32'd999999);
    applyStimulus(32'd1000000);
    checkOutput("dir_1e6_ovf", 64'(bus.ovf), 64'd1);
    applyStimulus(32'h8000_0000);
    checkOutput("dir_min_bcd", 64'(bus.bcd), 64'h483648);
    applyStimulus(32'd0);
    checkOutput("dir_zero_blank", 64'(bus.blank), 64'b111110);
    applyStimulus(32'hFFFF_FFFF);

    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 2))
        0:       v = $urandom;
        1:       v = 32'($signed($urandom_range(0, 1999999)) - 1000000);
        default: v = 32'($urandom_range(0, 9999));
      endcase
      applyStimulus(v);
    end

    // A second start mid-conversion must be ignored.
    @(negedge clk);
    bus.bin   = 32'd777;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    pulses    = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 10) begin bus.bin = 32'd555; bus.start = 1'b1; end
      if (c == 11) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        pulses++;
        checkOutput("ignore_start_cycle", 64'(c), 64'd32);
        checkResult(32'd777);
      end
    end
    checkOutput("ignore_start_pulses", 64'(pulses), 64'd1);

    // Start held high gives back-to-back conversions 33 clocks apart.
    @(negedge clk);
    bus.bin   = 32'd31415;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.bin   = -32'sd271828;
    waitDone(cycles);
    checkOutput("b2b_first_latency", 64'(cycles), 64'd32);
    checkResult(32'd31415);
    @(posedge clk); #1;
    waitDone(cycles);
    bus.start = 1'b0;
    checkOutput("b2b_period", 64'(cycles + 1), 64'd33);
    checkResult(-32'sd271828);
    @(posedge clk); #1;
    waitDone(cycles);

    // Reset partway through a conversion aborts with no done pulse.
    @(negedge clk);
    bus.bin   = 32'd654321;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("abort_busy",  64'(bus.busy),  64'd0);
    checkOutput("abort_done",  64'(bus.done),  64'd0);
    checkOutput("abort_bcd",   64'(bus.bcd),   64'd0);
    checkOutput("abort_neg",   64'(bus.neg),   64'd0);
    checkOutput("abort_ovf",   64'(bus.ovf),   64'd0);
    checkOutput("abort_blank", 64'(bus.blank), 64'b111110);
    @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    checkOutput("abort_no_done", 64'(pulses), 64'd0);
    applyStimulus(32'd654321);
    applyStimulus($urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd.md
# bin_to_bcd

Sequential binary-to-BCD decoder for the calculator's display path; it is the inverse of the keypad input path's BCD-to-binary encoding. It converts the arithmetic unit's 32-bit two's-complement result into sign, six BCD digits, a leading-zero blank mask and an overflow flag. The conversion is iterative (shift-and-add-3, one bit per clock). The result feeds the output unit's seven-segment decode.

## Interface
- BIN_W, 32: width of the two's-complement input.
- DIGITS, 6: number of BCD digits presented, matching HEX5..HEX0.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  input  BIN_W  two's-complement value; sampled on the start edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when the results update.
- bcd  output  4*DIGITS  magnitude digits; digit 0 is in bits [3:0].
- neg  output  1  high when the sampled input was negative.
- ovf  output  1  high when the magnitude exceeds 999999; bcd then holds the low six digits.
- blank  output  DIGITS  bit i high means digit i is a leading zero. Bit 0 is never set.

## Operation
- States are IDLE and SHIFT.
- **IDLE, start=1:**
  - Capture neg = bin[BIN_W-1].
  - Capture the 32-bit unsigned magnitude |bin|. For -2^31 the magnitude is 0x8000_0000, and no error is raised.
  - Clear the 40-bit (10-digit) scratch register.
  - Clear the bit counter and go to SHIFT.
- **Each SHIFT cycle:**
  - Every scratch digit >= 5 gets +3.
  - Then {scratch, magnitude} shifts left by 1.
  - The counter increments.
- **Exit from SHIFT:** on the cycle the counter reaches BIN_W-1, that cycle's adjust+shift result is used directly. At that edge:
  - bcd is loaded with the low DIGITS scratch digits.
  - ovf is loaded with (upper 4 digits != 0).
  - neg_out is loaded from the captured sign.
  - blank is loaded from the new digits.
  - done is set to 1 and the state returns to IDLE.
- **blank rule:** for i = DIGITS-1 down to 1, blank[i] = 1 when digit i and every higher digit are 0. When ovf=1, blank is all zeros.
- **start while busy:** ignored, with no queueing.
- **Output holding:** outputs hold their last completed result until the next completion. They are never partially updated.
- **Zero input:** produces neg=0, bcd=0, blank=6'b111110.

## Timing
- Reset values: state IDLE, busy=0, done=0, bcd=0, neg=0, ovf=0, blank=6'b111110, scratch and counter 0.
- Reset asserted mid-conversion aborts immediately to these values. No done pulse is produced.
- Sequence for a start sampled at edge E0:
  - busy=1 after E0.
  - Shifts occur at E1..E32.
  - After E32, done=1 for exactly one cycle, busy=0, and the results are valid.
  - Latency is therefore 32 clocks from the start edge to done.
- Back-to-back conversions: start held high while in IDLE at E32+1 begins the next conversion. The minimum period is 33 clocks.
- done and busy are never high in the same cycle.
- bin need not be held after the start edge.

## Structure
- Shared package calc_pkg holds:
  - BIN_W and DIGITS defaults.
  - The state enum (IDLE, SHIFT).
  - Constant SCRATCH_DIGITS=10.
- One sub-module, bcd_digit_adjust: a 4-bit in, 4-bit out "add 3 if >= 5" unit, instantiated once per scratch digit.
- Counter width is $clog2(BIN_W).

## Test plan
- reset low, then release with no start -> bcd=0, neg=0, ovf=0, blank=6'b111110, busy=0, done=0.
- bin=123, start pulse -> done exactly 32 cycles later. Results: bcd=24'h000123, neg=0, ovf=0, blank=6'b111000.
- bin=-45 -> bcd=24'h000045, neg=1, blank=6'b111100. bin=999999 -> bcd=24'h999999, ovf=0, blank=0.
- bin=1000000 -> ovf=1, bcd=24'h000000, blank=0. bin=-2147483648 -> neg=1, ovf=1, bcd=24'h483648.
- start pulsed again 10 cycles into a conversion, with a different bin -> ignored. Exactly one done pulse occurs, carrying the first value.
- reset asserted at cycle 15 of a conversion -> all outputs return to reset values at once, with no done. A new start afterwards converts correctly.
